switch_debouncer: RTL and testbench
===================================

# switch_debouncer

Synchronises and debounces a vector of raw board switch or button inputs into a clean, stable vector. Directly upstream of `combinational_logic`: `sw_stable` drives its 8-bit `task3_in`, so workshop designs see glitch-free switch values. Every change of the stable vector is also offered on a one-entry valid/ready event port, for logging or for a downstream FSM.

## Interface
- `WIDTH`, 8: number of switch inputs.
- `SYNC_STAGES`, 2: synchroniser flops per bit; legal range is 2 or more.
- `STABLE_CYCLES`, 16: number of consecutive mismatching synchronised samples needed to accept a new level; legal range is 2 or more.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `sw_raw`  in  WIDTH  asynchronous raw switch levels.
- `sw_stable`  out  WIDTH  debounced levels, registered.
- `change_valid`  out  1  an event is held in the buffer.
- `change_ready`  in  1  consumer accepts the event.
- `change_data`  out  WIDTH  value of `sw_stable` captured at the event.
- `change_overrun`  out  1  one or more events were overwritten before acceptance.

## Operation
- **Reset.** While `rst` is high at an edge, all of the following become 0: synchroniser flops, counters, `sw_stable`, `change_valid`, `change_data`, `change_overrun`. No event is generated when leaving reset.
- **Synchroniser.** Each bit passes through a `SYNC_STAGES`-deep flop chain. `sync[i]` is the last stage.
- **Per-bit counter.** Width is `$clog2(STABLE_CYCLES)`. At each edge:
  - if `sync[i] == sw_stable[i]`, the counter is set to 0;
  - otherwise, if the counter equals `STABLE_CYCLES-1`, `sw_stable[i]` takes `sync[i]` and the counter is set to 0;
  - otherwise the counter increments.
- **Glitch rejection.** Any bounce back to the stable level restarts the count, so pulses shorter than `STABLE_CYCLES` synchronised cycles never appear on `sw_stable`.
- **Event detection.** An event occurs on any edge where one or more bits of `sw_stable` flip. Several bits flipping on the same edge form one event. `change_data` takes the new `sw_stable` value.
- **Event buffer.** One entry. Rules per edge, with `acc = change_valid & change_ready`:
  - event and buffer empty: load data, `change_valid` becomes 1.
  - event and `acc`: load new data, `change_valid` stays 1, `change_overrun` is cleared.
  - event, buffer full, no `acc`: overwrite `change_data` with the newest value, `change_valid` stays 1, `change_overrun` becomes 1.
  - no event and `acc`: `change_valid` becomes 0 and `change_overrun` becomes 0; `change_data` holds its value.
  - no event, no `acc`: no change.
- **Handshake rules.**
  - `change_valid`, once high, stays high until accepted.
  - `change_data` and `change_overrun` are stable while valid is high and no event occurs.
  - `change_ready` may be high with `change_valid` low; this has no effect.
- `sw_stable` does not depend on `change_ready`, so backpressure never stalls debouncing.

## Timing
- **Latency.** If `sw_raw[i]` changes before edge N and then holds, `sw_stable[i]` updates at edge N+`SYNC_STAGES`+`STABLE_CYCLES`-1. With defaults that is edge N+17.
- **Event timing.** `change_valid` rises on the same edge as the `sw_stable` update, so the event latency is identical.
- **Throughput.** A single bit changes at most once per `STABLE_CYCLES` cycles. With back-to-back acceptance the port sustains one event per cycle.
- **Reset mid-count.** Reset discards a partial count and any pending event on that edge.
- **Combinational paths.** None from inputs to outputs; all outputs are registered.

## Structure
- **Package `debounce_pkg`.**
  - Default constants `DEB_WIDTH = 8`, `DEB_SYNC_STAGES = 2`, `DEB_STABLE_CYCLES = 16`.
  - Function `cnt_width(stable_cycles)` returning `$clog2(stable_cycles)`.
- **Sub-module `debounce_bit`.**
  - Contains the synchroniser chain, counter and stable flop for one bit.
  - Outputs the stable level and a one-cycle `flip` pulse.
  - Instantiated `WIDTH` times in a generate loop.
- **Top level.** `switch_debouncer` holds the OR of the flip pulses and the event buffer.
- **Elaboration check.** An `initial` assertion fails if `SYNC_STAGES < 2` or `STABLE_CYCLES < 2`.

## Test plan
All scenarios use default parameters.
1. **Reset:** hold `rst` for 3 cycles with `sw_raw = 8'hFF` -> every output is 0 during reset; after release, `sw_stable` becomes `8'hFF` exactly 18 edges after release. No event during reset itself.
2. **Latency:** from reset-stable 0, set `sw_raw = 8'h5A` before edge N, with `change_ready = 0` -> at edge N+17, `sw_stable = 8'h5A`, `change_valid = 1`, `change_data = 8'h5A`, `change_overrun = 0`. No change before edge N+17.
3. **Glitch rejection:** from stable 0, raise `sw_raw[0]` for 10 cycles and drop it, then raise it for 15 cycles and drop it -> `sw_stable` stays `8'h00` and `change_valid` never rises.
4. **Overrun:** with `change_ready = 0`, produce stable values `8'h01` then `8'h03` -> `change_data = 8'h03`, `change_overrun = 1`. Then assert `change_ready` for one cycle -> next edge `change_valid = 0`, `change_overrun = 0`.
5. **Simultaneous accept and event:** hold `change_ready = 1` so that `8'h01` is accepted on the same edge where `8'h03` becomes stable -> `change_valid` stays 1, `change_data = 8'h03`, `change_overrun = 0`.
6. **Backpressure independence:** hold `change_ready = 0` for 200 cycles while toggling `sw_raw` in slow steps `8'h00` -> `8'hF0` -> `8'h0F` -> `sw_stable` follows each step with 18-edge latency regardless of the handshake.

Source files
------------

// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared defaults and helpers for the switch debouncer
package debounce_pkg;

  localparam int DEB_WIDTH         = 8;
  localparam int DEB_SYNC_STAGES   = 2;
  localparam int DEB_STABLE_CYCLES = 16;

  // Counter width needed to count up to stable_cycles-1
  function automatic int cnt_width(input int stable_cycles);
    return $clog2(stable_cycles);
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - synchroniser, stability counter and stable flop for one switch bit
module debounce_bit
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = DEB_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEB_STABLE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic flip
);

  localparam int            CW      = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [CW-1:0]          cnt_q;

  assign sync = sync_q[SYNC_STAGES-1];

  // High on the cycle whose closing edge will move level; lets the top
  // register the event on the same edge as the level update.
  assign flip = (sync != level) && (cnt_q == CNT_MAX);

  // Metastability chain: raw enters at bit 0, sync is the last stage
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  // Count consecutive mismatching samples; any bounce back restarts the count
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      level <= 1'b0;
    end else if (sync == level) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_MAX) begin
      level <= sync;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/switch_debouncer.sv
// rtl/switch_debouncer.sv - debounced switch vector with one-entry change event port
module switch_debouncer
  import debounce_pkg::*;
#(
  parameter int WIDTH         = DEB_WIDTH,
  parameter int SYNC_STAGES   = DEB_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEB_STABLE_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic             change_valid,
  input  logic             change_ready,
  output logic [WIDTH-1:0] change_data,
  output logic             change_overrun
);

  if (SYNC_STAGES < 2 || STABLE_CYCLES < 2) begin : g_bad_params
    $error("switch_debouncer: SYNC_STAGES and STABLE_CYCLES must both be at least 2");
  end

  logic [WIDTH-1:0] flip_vec;
  logic [WIDTH-1:0] stable_next;
  logic             evt;
  logic             acc;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_bit (
      .clk  (clk),
      .rst  (rst),
      .raw  (sw_raw[i]),
      .level(sw_stable[i]),
      .flip (flip_vec[i])
    );
  end

  // Value sw_stable takes on the coming edge; all bits flipping together form one event
  assign stable_next = sw_stable ^ flip_vec;
  assign evt         = |flip_vec;
  assign acc         = change_valid & change_ready;

  // One-entry event buffer: newest value wins, overrun marks a lost unaccepted event
  always_ff @(posedge clk) begin
    if (rst) begin
      change_valid   <= 1'b0;
      change_data    <= '0;
      change_overrun <= 1'b0;
    end else if (evt) begin
      change_valid   <= 1'b1;
      change_data    <= stable_next;
      change_overrun <= change_valid & ~change_ready;
    end else if (acc) begin
      change_valid   <= 1'b0;
      change_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// tb/tb_switch_debouncer.sv - directed self-checking bench for switch_debouncer
module tb_switch_debouncer;

  logic       clk;
  logic       rst;
  logic [7:0] sw_raw;
  logic [7:0] sw_stable;
  logic       change_valid;
  logic       change_ready;
  logic [7:0] change_data;
  logic       change_overrun;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];

  switch_debouncer dut (
    .clk           (clk),
    .rst           (rst),
    .sw_raw        (sw_raw),
    .sw_stable     (sw_stable),
    .change_valid  (change_valid),
    .change_ready  (change_ready),
    .change_data   (change_data),
    .change_overrun(change_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a new raw level, confirm nothing moves for 17 edges, then the update on edge 18
  task automatic step(input logic [7:0] raw, input logic [7:0] old_val, input bit quiet,
                      input string tag);
    sw_raw = raw;
    for (int i = 1; i <= 17; i++) begin
      tick();
      chk({tag, "_hold"}, sw_stable, old_val);
      if (quiet) chk({tag, "_novalid"}, change_valid, 1'b0);
    end
    tick();
    chk({tag, "_update"}, sw_stable, raw);
  endtask

  // Consume the held event and compare it against the scoreboard head
  task automatic accept(input string tag);
    logic [7:0] e;
    chk({tag, "_valid"}, change_valid, 1'b1);
    chk({tag, "_sb_nonempty"}, exp_q.size() != 0, 1'b1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, "_data"}, change_data, e);
    end
    change_ready = 1'b1;
    tick();
    change_ready = 1'b0;
    chk({tag, "_cleared"}, {change_valid, change_overrun}, 2'b00);
  endtask

  initial begin
    logic [7:0] e;
    rst          = 1'b1;
    sw_raw       = 8'hFF;
    change_ready = 1'b0;

    // Reset held for 3 edges with all switches high
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_outputs", {sw_stable, change_valid, change_data, change_overrun}, 18'h0);
    end
    rst = 1'b0;
    exp_q.push_back(8'hFF);
    step(8'hFF, 8'h00, 1'b1, "rst_release");
    chk("rst_evt_valid", change_valid, 1'b1);
    accept("rst_acc");

    // Latency from a stable-zero baseline
    exp_q.push_back(8'h00);
    step(8'h00, 8'hFF, 1'b1, "to_zero");
    accept("zero_acc");
    exp_q.push_back(8'h5A);
    step(8'h5A, 8'h00, 1'b1, "lat");
    chk("lat_valid", change_valid, 1'b1);
    chk("lat_data", change_data, 8'h5A);
    chk("lat_ovr", change_overrun, 1'b0);
    accept("lat_acc");
    exp_q.push_back(8'h00);
    step(8'h00, 8'h5A, 1'b1, "lat_back");
    accept("lat_back_acc");

    // Glitch rejection: 10- and 15-cycle pulses must vanish
    sw_raw = 8'h01;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("glitch10", {sw_stable, change_valid}, 9'h0);
    end
    sw_raw = 8'h00;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("glitch_gap", {sw_stable, change_valid}, 9'h0);
    end
    sw_raw = 8'h01;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("glitch15", {sw_stable, change_valid}, 9'h0);
    end
    sw_raw = 8'h00;
    for (int i = 0; i < 25; i++) begin
      tick();
      chk("glitch_tail", {sw_stable, change_valid}, 9'h0);
    end

    // Overrun: second event lands while the first is still unaccepted
    step(8'h01, 8'h00, 1'b1, "ovr_a");
    chk("ovr_a_data", change_data, 8'h01);
    chk("ovr_a_flag", change_overrun, 1'b0);
    exp_q.push_back(8'h03);
    step(8'h03, 8'h01, 1'b0, "ovr_b");
    chk("ovr_b_data", change_data, 8'h03);
    chk("ovr_b_flag", change_overrun, 1'b1);
    accept("ovr_acc");
    exp_q.push_back(8'h00);
    step(8'h00, 8'h03, 1'b1, "ovr_back");
    accept("ovr_back_acc");

    // Accept on the same edge a new value becomes stable
    exp_q.push_back(8'h01);
    step(8'h01, 8'h00, 1'b1, "sim_a");
    exp_q.push_back(8'h03);
    sw_raw = 8'h03;
    for (int i = 1; i <= 17; i++) begin
      tick();
      chk("sim_hold", sw_stable, 8'h01);
    end
    e = exp_q.pop_front();
    chk("sim_a_data", change_data, e);
    change_ready = 1'b1;
    tick();
    change_ready = 1'b0;
    chk("sim_stable", sw_stable, 8'h03);
    chk("sim_valid", change_valid, 1'b1);
    chk("sim_data", change_data, 8'h03);
    chk("sim_ovr", change_overrun, 1'b0);
    accept("sim_b_acc");
    exp_q.push_back(8'h00);
    step(8'h00, 8'h03, 1'b1, "sim_back");
    accept("sim_back_acc");

    // Backpressure independence: ready low throughout, stable still tracks
    step(8'hF0, 8'h00, 1'b0, "bp_f0");
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("bp_f0_idle", sw_stable, 8'hF0);
    end
    step(8'h0F, 8'hF0, 1'b0, "bp_0f");
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("bp_0f_idle", sw_stable, 8'h0F);
    end
    exp_q.push_back(8'h00);
    step(8'h00, 8'h0F, 1'b0, "bp_00");
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("bp_00_idle", sw_stable, 8'h00);
    end
    chk("bp_ovr", change_overrun, 1'b1);
    accept("bp_acc");

    // Ready high with nothing pending changes nothing
    change_ready = 1'b1;
    tick();
    tick();
    change_ready = 1'b0;
    chk("idle_ready", {change_valid, change_overrun, change_data}, 10'h0);

    chk("sb_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
